// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and lap/clear buttons drive a 4-state FSM that gates counting.
// Optional LAP state is enabled by defining STOPWATCH_LAP_EN; without it lap_hold is tied low.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       tick,
  output logic       cnt_tick,
  output logic       run_en,
  output logic       clear_pulse,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_LAP     = 2'd3
  } state_t;

  localparam int              NB       = 2;
  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);

  // Bit 0 is start/stop, bit 1 is lap/clear throughout the button path.
  logic [NB-1:0]   w_btn_raw;
  logic [NB-1:0]   r_sync1, r_sync2, r_stable, r_stable_d, r_press;
  logic [DB_W-1:0] r_db_cnt [NB];

  assign w_btn_raw = {btn_lap_clear, btn_start_stop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
      // NOTE: the counter array is small flop state, not a RAM, so it is reset like any other register.
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage see the previous-cycle value of the one before it.
      r_sync1    <= w_btn_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LIMIT) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic   w_s, w_l;
  state_t r_state, w_state_next;
  logic   w_clear_next;
  logic   r_run_en, r_clear_pulse;

  assign w_s = r_press[0];
  assign w_l = r_press[1];

  // Start/stop is tested first, so a simultaneous lap/clear press is dropped.
  always_comb begin
    // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
    w_state_next = r_state;
    w_clear_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_s)      w_state_next = S_RUNNING;
        else if (w_l) w_clear_next = 1'b1;
      end
      S_RUNNING: begin
        if (w_s)      w_state_next = S_PAUSED;
`ifdef STOPWATCH_LAP_EN
        else if (w_l) w_state_next = S_LAP;
`endif
      end
      S_PAUSED: begin
        if (w_s) begin
          w_state_next = S_RUNNING;
        end else if (w_l) begin
          w_state_next = S_IDLE;
          w_clear_next = 1'b1;
        end
      end
      S_LAP: begin
        if (w_s)      w_state_next = S_PAUSED;
        else if (w_l) w_state_next = S_RUNNING;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_hold;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_run_en      <= 1'b0;
      r_clear_pulse <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap_hold    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_run_en      <= (w_state_next == S_RUNNING) || (w_state_next == S_LAP);
      r_clear_pulse <= w_clear_next;
`ifdef STOPWATCH_LAP_EN
      r_lap_hold    <= (w_state_next == S_LAP);
`endif
    end
  end

`ifdef STOPWATCH_LAP_EN
  assign lap_hold = r_lap_hold;
`else
  assign lap_hold = 1'b0;
`endif

  assign state       = r_state;
  assign run_en      = r_run_en;
  assign clear_pulse = r_clear_pulse;
  assign cnt_tick    = tick & r_run_en;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues cycle-stamped expectations, a negedge monitor compares.
module tb_stopwatch_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;
`ifdef STOPWATCH_LAP_EN
  localparam logic [1:0] ST_L_FROM_RUN = ST_LAP;
`else
  localparam logic [1:0] ST_L_FROM_RUN = ST_RUN;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_lap_clear;
  logic       tick;
  logic       cnt_tick;
  logic       run_en;
  logic       clear_pulse;
  logic       lap_hold;
  logic [1:0] state;

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] cur_st = ST_IDLE;

  int         q_cyc [$];
  logic [5:0] q_exp [$];
  string      q_name[$];

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_lap_clear (btn_lap_clear),
    .tick          (tick),
    .cnt_tick      (cnt_tick),
    .run_en        (run_en),
    .clear_pulse   (clear_pulse),
    .lap_hold      (lap_hold),
    .state         (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got {st,run,hold,clr,ct}=%b expected %b", name, cyc, act, exp);
    end
  endtask

  // Expected vector {state, run_en, lap_hold, clear_pulse, cnt_tick} at edge index 'at'.
  task automatic push(input int at, input logic [1:0] st, input logic clr, input logic ct, input string name);
    logic run, hold;
    run  = (st == ST_RUN) || (st == ST_LAP);
    hold = (st == ST_LAP);
    q_cyc.push_back(at);
    q_exp.push_back({st, run, hold, clr, ct});
    q_name.push_back(name);
  endtask

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int         c_at;
      logic [5:0] e;
      string      n;
      c_at = q_cyc.pop_front();
      e    = q_exp.pop_front();
      n    = q_name.pop_front();
      if (c_at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed: due cyc %0d, now %0d", n, c_at, cyc);
      end else begin
        check(n, {state, run_en, lap_hold, clear_pulse, cnt_tick}, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: first sample at cyc+1, state changes at cyc+9 with DEBOUNCE_CYCLES=4.
  task automatic press(input logic ss, input logic lc, input logic [1:0] nst, input logic nclr, input string name);
    int c;
    c = cyc;
    push(c + 8,  cur_st, 1'b0, 1'b0, {name, "_pre"});
    push(c + 9,  nst,    nclr, 1'b0, name);
    push(c + 10, nst,    1'b0, 1'b0, {name, "_post"});
    btn_start_stop = ss;
    btn_lap_clear  = lc;
    step(6);
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
    step(10);
    cur_st = nst;
  endtask

  initial begin
    int c;
    reset          = 1'b0;
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
    tick           = 1'b0;
    push(2, ST_IDLE, 1'b0, 1'b0, "reset_state");
    step(3);
    reset = 1'b1;
    step(2);

    press(1'b1, 1'b0, ST_RUN, 1'b0, "start");

    // Bounce on start/stop: 3 high, 2 low, 3 high; every run is shorter than the debounce window.
    c = cyc;
    push(c + 5,  ST_RUN, 1'b0, 1'b0, "bounce_a");
    push(c + 10, ST_RUN, 1'b0, 1'b0, "bounce_b");
    push(c + 15, ST_RUN, 1'b0, 1'b0, "bounce_c");
    push(c + 20, ST_RUN, 1'b0, 1'b0, "bounce_d");
    btn_start_stop = 1'b1; step(3);
    btn_start_stop = 1'b0; step(2);
    btn_start_stop = 1'b1; step(3);
    btn_start_stop = 1'b0; step(14);

    press(1'b0, 1'b1, ST_L_FROM_RUN, 1'b0, "lap_enter");

    c = cyc;
    tick = 1'b1;
    push(c, cur_st, 1'b0, 1'b1, "tick_in_lap");
    step(1);
    tick = 1'b0;
    push(cyc, cur_st, 1'b0, 1'b0, "tick_low_lap");
    step(2);

    press(1'b0, 1'b1, ST_RUN, 1'b0, "lap_leave");
    press(1'b1, 1'b0, ST_PAUSE, 1'b0, "pause");

    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      push(cyc, ST_PAUSE, 1'b0, 1'b0, "tick_paused");
      step(1);
      tick = 1'b0;
      step(1);
    end

    press(1'b0, 1'b1, ST_IDLE, 1'b1, "clear_from_pause");
    press(1'b1, 1'b1, ST_RUN, 1'b0, "both_start_wins");
    press(1'b0, 1'b1, ST_L_FROM_RUN, 1'b0, "lap_again");

    // Reset mid-debounce with lap/clear held through release.
    btn_lap_clear = 1'b1;
    step(3);
    reset = 1'b0;
    push(cyc,     ST_IDLE, 1'b0, 1'b0, "reset_async");
    push(cyc + 1, ST_IDLE, 1'b0, 1'b0, "reset_held");
    step(2);
    reset  = 1'b1;
    cur_st = ST_IDLE;
    c = cyc;
    push(c + 8,  ST_IDLE, 1'b0, 1'b0, "held_pre");
    push(c + 9,  ST_IDLE, 1'b1, 1'b0, "held_clear");
    push(c + 10, ST_IDLE, 1'b0, 1'b0, "held_post");
    step(12);
    btn_lap_clear = 1'b0;
    step(10);

    if (q_cyc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover %0d expectations never compared", q_cyc.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout at cyc %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
